// File: rtl/spi_pkg.sv
// spi_pkg: shared types for the SPI frame slave.
// FSM state encoding and error counter width.
package spi_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_t;

  localparam int SPI_ERR_CNT_W = 8;

endpackage

// File: rtl/spi_sync.sv
// spi_sync: synchroniser for sclk/mosi/cs_n plus
// SCLK leading/trailing and cs_n edge detection.
module spi_sync #(
  parameter int SYNC_STAGES = 2,
  parameter bit CPOL        = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk,
  input  logic mosi,
  input  logic cs_n,
  output logic mosi_s,
  output logic lead,
  output logic trail,
  output logic cs_fall,
  output logic cs_rise
);

  logic [SYNC_STAGES-1:0][2:0] stg;
  logic sclk_s;
  logic cs_s;
  logic sclk_d;
  logic cs_d;

  // Reset to 0 so a low cs_n after reset never looks like a fall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stg    <= '0;
      sclk_d <= 1'b0;
      cs_d   <= 1'b0;
    end else begin
      stg    <= {stg[SYNC_STAGES-2:0], {sclk, mosi, cs_n}};
      sclk_d <= sclk_s;
      cs_d   <= cs_s;
    end
  end

  assign sclk_s  = stg[SYNC_STAGES-1][2];
  assign mosi_s  = stg[SYNC_STAGES-1][1];
  assign cs_s    = stg[SYNC_STAGES-1][0];
  assign lead    = (sclk_s != sclk_d) && (sclk_d == CPOL);
  assign trail   = (sclk_s != sclk_d) && (sclk_s == CPOL);
  assign cs_fall = cs_d & ~cs_s;
  assign cs_rise = ~cs_d & cs_s;

endmodule

// File: rtl/spi_frame_slave.sv
// spi_frame_slave: oversampled SPI slave, any width/mode.
// Define SPI_FRAME_SLAVE_ERR_EN for abort pulse/counter.
import spi_pkg::*;

module spi_frame_slave #(
  parameter int WIDTH       = 8,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sclk,
  input  logic                     mosi,
  input  logic                     cs_n,
  output logic                     miso,
  output logic                     miso_oe,
  input  logic [WIDTH-1:0]         tx_data,
  input  logic                     tx_load,
  output logic [WIDTH-1:0]         rx_data,
  output logic                     rx_valid,
  output logic                     busy,
  output logic                     frame_err,
  output logic [SPI_ERR_CNT_W-1:0] err_count
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic mosi_s, lead, trail, cs_fall, cs_rise;
  logic samp, shft;

  spi_state_t state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic [WIDTH-1:0] rxo_q, rxo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             miso_q, miso_d;
  logic             rxv_q, rxv_d;

  spi_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .CPOL       (CPOL)
  ) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .sclk   (sclk),
    .mosi   (mosi),
    .cs_n   (cs_n),
    .mosi_s (mosi_s),
    .lead   (lead),
    .trail  (trail),
    .cs_fall(cs_fall),
    .cs_rise(cs_rise)
  );

  assign samp   = CPHA ? trail : lead;
  assign shft   = CPHA ? lead : trail;
  assign hold_d = tx_load ? tx_data : hold_q;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rxo_q   <= '0;
      cnt_q   <= '0;
      miso_q  <= 1'b0;
      rxv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rxo_q   <= rxo_d;
      cnt_q   <= cnt_d;
      miso_q  <= miso_d;
      rxv_q   <= rxv_d;
    end
  end

  // Next state: entry load, sample, shift and frame wrap.
  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rxo_d   = rxo_q;
    cnt_d   = cnt_q;
    miso_d  = miso_q;
    rxv_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = SHIFT;
          tx_d    = hold_d;
          cnt_d   = '0;
          miso_d  = CPHA ? 1'b0 : hold_d[WIDTH-1];
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d = IDLE;
          miso_d  = 1'b0;
        end else if (samp) begin
          rx_d = {rx_q[WIDTH-2:0], mosi_s};
          if (cnt_q == LAST) begin
            cnt_d = '0;
            rxo_d = {rx_q[WIDTH-2:0], mosi_s};
            rxv_d = 1'b1;
            tx_d  = hold_d;
            if (!CPHA) miso_d = hold_d[WIDTH-1];
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (shft) begin
          if (CPHA) begin
            miso_d = tx_q[WIDTH-1];
            tx_d   = tx_q << 1;
          end else if (cnt_q != '0) begin
            miso_d = tx_q[WIDTH-2];
            tx_d   = tx_q << 1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign miso     = miso_q;
  assign miso_oe  = (state_q == SHIFT);
  assign busy     = (state_q == SHIFT);
  assign rx_data  = rxo_q;
  assign rx_valid = rxv_q;

`ifdef SPI_FRAME_SLAVE_ERR_EN
  logic                     ferr_q;
  logic [SPI_ERR_CNT_W-1:0] ecnt_q;
  logic                     abort;

  assign abort = (state_q == SHIFT) && cs_rise && (cnt_q != '0);

  // Abort pulse and saturating abort counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ferr_q <= 1'b0;
      ecnt_q <= '0;
    end else begin
      ferr_q <= abort;
      if (abort && (ecnt_q != '1))
        ecnt_q <= ecnt_q + 1'b1;
    end
  end

  assign frame_err = ferr_q;
  assign err_count = ecnt_q;
`else
  assign frame_err = 1'b0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_spi_frame_slave.sv
// tb_spi_frame_slave: mode 0 / 8-bit and mode 3 / 16-bit
// slaves driven by a bit-level master and a word model.
module tb_spi_frame_slave;

  localparam int H = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] sclk_v, mosi_v, cs_v, miso_v, oe_v;
  logic [1:0] load_v, rxv_v, busy_v, ferr_v;
  logic [7:0]  txd0, rxd0, ecnt0;
  logic [15:0] txd1, rxd1;
  logic [7:0]  ecnt1;

  int WID[2]  = '{8, 16};
  bit CPOLv[2] = '{1'b0, 1'b1};
  bit CPHAv[2] = '{1'b0, 1'b1};

  logic [15:0] hold[2];
  logic [7:0]  q0[$];
  logic [15:0] q1[$];
  int ferr_n0 = 0;
  int both_n = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_frame_slave #(.WIDTH(8), .CPOL(1'b0), .CPHA(1'b0),
    .SYNC_STAGES(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk_v[0]),
    .mosi(mosi_v[0]), .cs_n(cs_v[0]), .miso(miso_v[0]),
    .miso_oe(oe_v[0]), .tx_data(txd0), .tx_load(load_v[0]),
    .rx_data(rxd0), .rx_valid(rxv_v[0]), .busy(busy_v[0]),
    .frame_err(ferr_v[0]), .err_count(ecnt0));

  spi_frame_slave #(.WIDTH(16), .CPOL(1'b1), .CPHA(1'b1),
    .SYNC_STAGES(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk_v[1]),
    .mosi(mosi_v[1]), .cs_n(cs_v[1]), .miso(miso_v[1]),
    .miso_oe(oe_v[1]), .tx_data(txd1), .tx_load(load_v[1]),
    .rx_data(rxd1), .rx_valid(rxv_v[1]), .busy(busy_v[1]),
    .frame_err(ferr_v[1]), .err_count(ecnt1));

  always @(negedge clk) begin
    if (rxv_v[0]) q0.push_back(rxd0);
    if (rxv_v[1]) q1.push_back(rxd1);
    if (ferr_v[0]) ferr_n0++;
    if ((rxv_v[0] && ferr_v[0]) || (rxv_v[1] && ferr_v[1]))
      both_n++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input int sel, input logic [15:0] v);
    if (sel == 0) txd0 = v[7:0];
    else txd1 = v;
    load_v[sel] = 1'b1;
    wclk(1);
    load_v[sel] = 1'b0;
    hold[sel] = (sel == 0) ? {8'h00, v[7:0]} : v;
  endtask

  task automatic cs_low(input int sel);
    cs_v[sel] = 1'b0;
    wclk(8);
  endtask

  task automatic cs_high(input int sel);
    wclk(H);
    cs_v[sel] = 1'b1;
    wclk(8);
  endtask

  task automatic xfer(input int sel, input logic [15:0] word,
                      input int nbits, output logic [15:0] got);
    logic b;
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      b = word[WID[sel]-1-i];
      if (!CPHAv[sel]) begin
        mosi_v[sel] = b;
        wclk(H);
        got = {got[14:0], miso_v[sel]};
        sclk_v[sel] = ~CPOLv[sel];
        wclk(H);
        sclk_v[sel] = CPOLv[sel];
      end else begin
        wclk(H);
        sclk_v[sel] = ~CPOLv[sel];
        mosi_v[sel] = b;
        wclk(H);
        got = {got[14:0], miso_v[sel]};
        sclk_v[sel] = CPOLv[sel];
      end
    end
  endtask

  task automatic frame_chk(input int sel, input logic [15:0] w,
                           input string tag);
    logic [15:0] got;
    int nb;
    nb = (sel == 0) ? q0.size() : q1.size();
    xfer(sel, w, WID[sel], got);
    wclk(12);
    if (sel == 0) begin
      chk({tag, " rx_valid count"}, 32'(q0.size()), 32'(nb + 1));
      if (q0.size() > 0) chk({tag, " rx_data"}, 32'(q0[$]), 32'(w[7:0]));
    end else begin
      chk({tag, " rx_valid count"}, 32'(q1.size()), 32'(nb + 1));
      if (q1.size() > 0) chk({tag, " rx_data"}, 32'(q1[$]), 32'(w));
    end
    chk({tag, " miso word"}, 32'(got), 32'(hold[sel]));
  endtask

  task automatic zero_chk(input string tag);
    chk({tag, " miso"}, 32'(miso_v), 32'(0));
    chk({tag, " miso_oe"}, 32'(oe_v), 32'(0));
    chk({tag, " rx_data0"}, 32'(rxd0), 32'(0));
    chk({tag, " rx_data1"}, 32'(rxd1), 32'(0));
    chk({tag, " rx_valid"}, 32'(rxv_v), 32'(0));
    chk({tag, " busy"}, 32'(busy_v), 32'(0));
    chk({tag, " frame_err"}, 32'(ferr_v), 32'(0));
    chk({tag, " err_count"}, 32'({ecnt0, ecnt1}), 32'(0));
  endtask

  initial begin
    logic [15:0] got;
    logic [15:0] w;
    logic [7:0]  last0;
    int sel, nf, nb, exp_err;

    rst_n = 1'b0;
    sclk_v = 2'b10;
    mosi_v = 2'b00;
    cs_v = 2'b11;
    load_v = 2'b00;
    txd0 = '0;
    txd1 = '0;
    hold[0] = '0;
    hold[1] = '0;
    exp_err = 0;
    wclk(5);
    zero_chk("reset");
    rst_n = 1'b1;
    wclk(5);

    load(0, 16'h000F);
    cs_low(0);
    chk("mode0 miso_oe", 32'(oe_v[0]), 32'(1));
    chk("mode0 busy", 32'(busy_v[0]), 32'(1));
    frame_chk(0, 16'h00A5, "mode0 A5");
    cs_high(0);
    chk("mode0 oe off", 32'(oe_v[0]), 32'(0));
    chk("mode0 idle", 32'(busy_v[0]), 32'(0));

    load(1, 16'hBEEF);
    cs_low(1);
    frame_chk(1, 16'h1234, "mode3 1234");
    cs_high(1);

    load(0, 16'h005A);
    cs_low(0);
    frame_chk(0, 16'h0011, "b2b 11");
    frame_chk(0, 16'h0022, "b2b 22");
    cs_high(0);

    for (int k = 0; k < 8; k++) begin
      sel = k % 2;
      nf = $urandom_range(1, 3);
      load(sel, 16'($urandom));
      cs_low(sel);
      for (int f = 0; f < nf; f++) begin
        w = 16'($urandom);
        if (sel == 0) w[15:8] = 8'h00;
        frame_chk(sel, w, "random");
      end
      cs_high(sel);
    end

    last0 = q0[$];
    nb = q0.size();
    cs_low(0);
    xfer(0, 16'h00FF, 5, got);
    cs_high(0);
`ifdef SPI_FRAME_SLAVE_ERR_EN
    exp_err = 1;
`endif
    chk("abort no rx_valid", 32'(q0.size()), 32'(nb));
    chk("abort rx_data kept", 32'(rxd0), 32'(last0));
    chk("abort frame_err", 32'(ferr_n0), 32'(exp_err));
    chk("abort err_count", 32'(ecnt0), 32'(exp_err));

`ifdef SPI_FRAME_SLAVE_ERR_EN
    for (int k = 0; k < 259; k++) begin
      cs_v[0] = 1'b0;
      wclk(8);
      xfer(0, 16'h0080, 1, got);
      cs_high(0);
    end
    exp_err = 260;
    chk("sat err_count", 32'(ecnt0), 32'(255));
`endif
    chk("abort pulses", 32'(ferr_n0), 32'(exp_err));
    chk("abort rx count", 32'(q0.size()), 32'(nb));

    cs_low(0);
    xfer(0, 16'h00C3, 3, got);
    rst_n = 1'b0;
    wclk(2);
    zero_chk("midreset");
    rst_n = 1'b1;
    hold[0] = '0;
    hold[1] = '0;
    wclk(10);
    chk("midreset idle", 32'(busy_v[0]), 32'(0));
    nb = q0.size();
    xfer(0, 16'h0099, 8, got);
    wclk(10);
    chk("midreset no rx", 32'(q0.size()), 32'(nb));
    chk("midreset still idle", 32'(busy_v[0]), 32'(0));
    chk("midreset oe", 32'(oe_v[0]), 32'(0));
    cs_high(0);
    cs_low(0);
    chk("rearm busy", 32'(busy_v[0]), 32'(1));
    frame_chk(0, 16'h003C, "rearm 3C");
    cs_high(0);

    chk("rx_valid with frame_err", 32'(both_n), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
